// File: rtl/mouse_cursor.sv
// Mouse-port consumer: runs the command/response toggle handshake with the USB
// controller and integrates each reported delta into a screen-clamped cursor.
module mouse_cursor #(
  parameter int unsigned X_MAX    = 639,
  parameter int unsigned Y_MAX    = 479,
  parameter int unsigned X_INIT   = 320,
  parameter int unsigned Y_INIT   = 240,
  parameter int unsigned POLL_GAP = 1000,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input  logic        clock,
  input  logic        clock_valid,
  input  logic        reset,
  input  logic        freeze,
  output logic        mouse_command,
  input  logic        mouse_response,
  input  logic [31:0] mouse_deltax,
  input  logic [31:0] mouse_deltay,
  input  logic        mouse_button1,
  input  logic        mouse_button2,
  input  logic        mouse_button3,
  output logic [9:0]  cursor_x,
  output logic [8:0]  cursor_y,
  output logic        button1,
  output logic        button2,
  output logic        button3,
  output logic        update,
  output logic        timeout
);

  localparam int unsigned GAP_W  = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned POS_W  = 34;

  localparam logic [GAP_W-1:0]        GAP_LAST  = GAP_W'(POLL_GAP - 1);
  localparam logic [WAIT_W-1:0]       WAIT_LAST = WAIT_W'(TIMEOUT);
  localparam logic signed [POS_W-1:0] X_MAX_S   = POS_W'(X_MAX);
  localparam logic signed [POS_W-1:0] Y_MAX_S   = POS_W'(Y_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_APPLY
  } state_t;

  state_t              state;
  logic [GAP_W-1:0]    gap_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [31:0]         dx_q;
  logic [31:0]         dy_q;
  logic [2:0]          btn_q;

  logic signed [POS_W-1:0] nx;
  logic signed [POS_W-1:0] ny;
  logic [9:0]              nx_clamp;
  logic [8:0]              ny_clamp;

  // 34-bit signed sum cannot overflow for any 32-bit delta; Y grows downwards.
  assign nx = $signed({24'd0, cursor_x}) + $signed({{2{dx_q[31]}}, dx_q});
  assign ny = $signed({25'd0, cursor_y}) - $signed({{2{dy_q[31]}}, dy_q});

  always_comb begin
    nx_clamp = nx[9:0];
    ny_clamp = ny[8:0];
    if (nx < 0)            nx_clamp = '0;
    else if (nx > X_MAX_S) nx_clamp = X_MAX_S[9:0];
    if (ny < 0)            ny_clamp = '0;
    else if (ny > Y_MAX_S) ny_clamp = Y_MAX_S[8:0];
  end

  // Handshake FSM; reset wins over clock_valid, everything else waits for it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= S_IDLE;
      gap_cnt       <= '0;
      wait_cnt      <= '0;
      mouse_command <= 1'b0;
      cursor_x      <= 10'(X_INIT);
      cursor_y      <= 9'(Y_INIT);
      button1       <= 1'b0;
      button2       <= 1'b0;
      button3       <= 1'b0;
      update        <= 1'b0;
      timeout       <= 1'b0;
      dx_q          <= '0;
      dy_q          <= '0;
      btn_q         <= '0;
    end else if (clock_valid) begin
      update <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gap_cnt == GAP_LAST) begin
            if (!freeze) state <= S_REQ;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        S_REQ: begin
          mouse_command <= ~mouse_command;
          wait_cnt      <= '0;
          state         <= S_WAIT;
        end
        S_WAIT: begin
          if (mouse_response == mouse_command) begin
            dx_q  <= mouse_deltax;
            dy_q  <= mouse_deltay;
            btn_q <= {mouse_button3, mouse_button2, mouse_button1};
            state <= S_APPLY;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_APPLY: begin
          cursor_x <= nx_clamp;
          cursor_y <= ny_clamp;
          button1  <= btn_q[0];
          button2  <= btn_q[1];
          button3  <= btn_q[2];
          update   <= 1'b1;
          gap_cnt  <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_cursor.sv
// Directed + randomized bench for mouse_cursor with a stub USB controller and
// an arithmetic cursor model.
module tb_mouse_cursor;

  localparam int POLL_GAP = 8;
  localparam int TIMEOUT  = 50;
  localparam int X_MAX    = 639;
  localparam int Y_MAX    = 479;
  localparam int LIMIT    = 4 * (POLL_GAP + 1) + 8;

  logic        clock = 1'b0;
  logic        clock_valid;
  logic        reset;
  logic        freeze;
  logic        mouse_command;
  logic        mouse_response;
  logic [31:0] mouse_deltax;
  logic [31:0] mouse_deltay;
  logic        mouse_button1, mouse_button2, mouse_button3;
  logic [9:0]  cursor_x;
  logic [8:0]  cursor_y;
  logic        button1, button2, button3;
  logic        update;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int mx, my;
  logic [2:0] mbtn;
  bit alt = 0;

  mouse_cursor #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_INIT(320), .Y_INIT(240),
    .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .clock_valid(clock_valid), .reset(reset), .freeze(freeze),
    .mouse_command(mouse_command), .mouse_response(mouse_response),
    .mouse_deltax(mouse_deltax), .mouse_deltay(mouse_deltay),
    .mouse_button1(mouse_button1), .mouse_button2(mouse_button2),
    .mouse_button3(mouse_button3),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .button1(button1), .button2(button2), .button3(button3),
    .update(update), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input longint v, input int hi);
    if (v < 0) return 0;
    if (v > longint'(hi)) return hi;
    return int'(v);
  endfunction

  // Advance one cycle; outputs are sampled and inputs driven at the falling edge.
  task automatic step();
    @(negedge clock);
    if (alt) clock_valid = ~clock_valid;
  endtask

  task automatic wait_toggle(output int n);
    logic prev;
    prev = mouse_command;
    n = 0;
    do begin
      step();
      n++;
    end while (mouse_command === prev && n < LIMIT);
    chk("toggle_seen", 32'(mouse_command !== prev), 32'd1);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_x"},  32'(cursor_x), 32'(mx));
    chk({tag, "_y"},  32'(cursor_y), 32'(my));
    chk({tag, "_b"},  32'({button3, button2, button1}), 32'(mbtn));
  endtask

  // Stub controller: echo the command after dly cycles with the given sample.
  task automatic respond(input logic [31:0] dx, input logic [31:0] dy,
                         input logic [2:0] b, input int dly);
    repeat (dly) step();
    mouse_deltax   = dx;
    mouse_deltay   = dy;
    {mouse_button3, mouse_button2, mouse_button1} = b;
    mouse_response = mouse_command;
    step();
    chk("upd_latch", 32'(update), 32'd0);
    mx   = clampi(longint'(mx) + longint'($signed(dx)), X_MAX);
    my   = clampi(longint'(my) - longint'($signed(dy)), Y_MAX);
    mbtn = b;
    step();
    chk("upd_apply", 32'(update), 32'd1);
    check_state("apply");
    step();
    chk("upd_after", 32'(update), 32'd0);
  endtask

  initial begin
    int n;
    int cnt;
    logic cmd;
    logic [31:0] dx, dy;

    clock_valid = 1'b0; reset = 1'b0; freeze = 1'b0;
    mouse_response = 1'b0; mouse_deltax = '0; mouse_deltay = '0;
    mouse_button1 = 1'b0; mouse_button2 = 1'b0; mouse_button3 = 1'b0;

    // Reset applies even with clock_valid low.
    step(); step();
    mx = 320; my = 240; mbtn = '0;
    chk("rst_cmd", 32'(mouse_command), 32'd0);
    chk("rst_upd", 32'(update), 32'd0);
    chk("rst_to",  32'(timeout), 32'd0);
    check_state("rst");
    reset = 1'b1; clock_valid = 1'b1;

    // Basic transaction.
    wait_toggle(n);
    chk("first_gap", 32'(n), 32'(POLL_GAP + 1));
    chk("first_cmd", 32'(mouse_command), 32'd1);
    respond(32'd10, 32'd20, 3'b001, 5);
    chk("basic_x", 32'(cursor_x), 32'd330);
    chk("basic_y", 32'(cursor_y), 32'd220);

    // Clamping at both ends, no wraparound.
    wait_toggle(n);
    chk("gap", 32'(n), 32'(POLL_GAP));
    respond(-32'sd1000, -32'sd1000, 3'b010, 2);
    chk("clamp_lo_x", 32'(cursor_x), 32'd0);
    chk("clamp_hi_y", 32'(cursor_y), 32'd479);
    wait_toggle(n);
    respond(32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'b100, 0);
    chk("clamp_hi_x", 32'(cursor_x), 32'd639);
    chk("clamp_lo_y", 32'(cursor_y), 32'd0);

    // Timeout: sticky, no re-request, late response still applied.
    wait_toggle(n);
    cmd = mouse_command;
    repeat (40) step();
    chk("to_early", 32'(timeout), 32'd0);
    repeat (30) step();
    chk("to_set", 32'(timeout), 32'd1);
    chk("to_no_rereq", 32'(mouse_command), 32'(cmd));
    respond(-32'sd5, -32'sd7, 3'b111, 0);
    chk("to_sticky", 32'(timeout), 32'd1);

    // Freeze through IDLE: no requests, no updates.
    freeze = 1'b1;
    cmd = mouse_command; cnt = 0;
    repeat (10 * POLL_GAP) begin
      step();
      if (update === 1'b1) cnt++;
    end
    chk("frz_cmd", 32'(mouse_command), 32'(cmd));
    chk("frz_upd", 32'(cnt), 32'd0);
    check_state("frz");
    freeze = 1'b0;
    wait_toggle(n);
    chk("unfrz_gap", 32'(n), 32'd2);
    // Freeze raised during WAIT: transaction completes, then nothing more.
    freeze = 1'b1;
    respond(32'd3, -32'sd4, 3'b110, 2);
    cmd = mouse_command; cnt = 0;
    repeat (10 * POLL_GAP) begin
      step();
      if (update === 1'b1) cnt++;
    end
    chk("frz2_cmd", 32'(mouse_command), 32'(cmd));
    chk("frz2_upd", 32'(cnt), 32'd0);
    freeze = 1'b0;

    // Reset dropped during WAIT with command=1 (zero delta still updates).
    wait_toggle(n);
    if (mouse_command === 1'b0) begin
      respond(32'd0, 32'd0, 3'b000, 1);
      wait_toggle(n);
    end
    chk("mid_cmd1", 32'(mouse_command), 32'd1);
    reset = 1'b0;
    step();
    mx = 320; my = 240; mbtn = '0;
    chk("mid_cmd", 32'(mouse_command), 32'd0);
    chk("mid_to",  32'(timeout), 32'd0);
    chk("mid_upd", 32'(update), 32'd0);
    check_state("mid");

    // Alternate clock_valid: twice the cycles, same result as the basic run.
    step();
    reset = 1'b1; clock_valid = 1'b0; alt = 1;
    wait_toggle(n);
    chk("alt_gap", 32'(n), 32'(2 * (POLL_GAP + 1)));
    repeat (3) step();
    mouse_deltax = 32'd10; mouse_deltay = 32'd20;
    {mouse_button3, mouse_button2, mouse_button1} = 3'b001;
    mouse_response = mouse_command;
    cnt = 0;
    while (update !== 1'b1 && cnt < 20) begin
      step();
      cnt++;
    end
    chk("alt_upd", 32'(update), 32'd1);
    mx = 330; my = 220; mbtn = 3'b001;
    check_state("alt");
    alt = 0; clock_valid = 1'b1;
    step(); step();

    // Randomized transactions against the model.
    for (int i = 0; i < 10; i++) begin
      wait_toggle(n);
      if (i > 0) chk("rnd_gap", 32'(n), 32'(POLL_GAP));
      if ($urandom_range(0, 3) == 0) dx = $urandom;
      else dx = 32'($urandom_range(0, 600)) - 32'd300;
      if ($urandom_range(0, 3) == 0) dy = $urandom;
      else dy = 32'($urandom_range(0, 600)) - 32'd300;
      respond(dx, dy, 3'($urandom_range(0, 7)), int'($urandom_range(0, 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
